// File: rtl/rs_issue_queue.sv
// Tomasulo reservation station: captures operands from the CDB, tracks issue order
// in an age matrix and dispatches the oldest fully-ready entry through a registered output stage.
module rs_issue_queue #(
  parameter int         DEPTH       = 4,
  parameter int         TAG_BASE    = 0,
  parameter logic [4:0] INVALID_TAG = 5'b11111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [3:0]  issue_op,
  input  logic [31:0] issue_val_1,
  input  logic [31:0] issue_val_2,
  input  logic [4:0]  issue_tag_1,
  input  logic [4:0]  issue_tag_2,
  output logic [4:0]  issue_alloc_tag,
  input  logic        cdb_valid,
  input  logic [4:0]  cdb_tag,
  input  logic [31:0] cdb_val,
  output logic        disp_valid,
  input  logic        disp_ready,
  output logic [3:0]  disp_op,
  output logic [31:0] disp_val_1,
  output logic [31:0] disp_val_2,
  output logic [4:0]  disp_tag,
  output logic [3:0]  count
);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];
  logic [3:0]       op_q    [DEPTH];
  logic [31:0]      val1_q  [DEPTH];
  logic [31:0]      val2_q  [DEPTH];
  logic [4:0]       tag1_q  [DEPTH];
  logic [4:0]       tag2_q  [DEPTH];
  logic [3:0]       count_q, count_d;
  logic             dvalid_q;
  logic [3:0]       dop_q;
  logic [31:0]      dval1_q, dval2_q;
  logic [4:0]       dtag_q;

  logic [DEPTH-1:0] rdy, sel;
  logic [IW-1:0]    alloc_idx, sel_idx;
  logic             has_free, any_rdy, accept, load;

  function automatic logic cdb_hit(input logic v, input logic [4:0] ct, input logic [4:0] t);
    return v && (ct != INVALID_TAG) && (ct == t);
  endfunction

  always_comb begin
    has_free  = 1'b0;
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        has_free  = 1'b1;
        alloc_idx = IW'(i);
      end
    end
    // An entry is selected when it is ready and no older entry is also ready.
    for (int i = 0; i < DEPTH; i++)
      rdy[i] = busy_q[i] && (tag1_q[i] == INVALID_TAG) && (tag2_q[i] == INVALID_TAG);
    any_rdy = |rdy;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = rdy[i];
      for (int j = 0; j < DEPTH; j++)
        if (rdy[j] && older_q[j][i]) sel[i] = 1'b0;
      if (sel[i]) sel_idx = IW'(i);
    end
    accept = issue_valid && has_free;
    load   = any_rdy && (!dvalid_q || disp_ready);
  end

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) older_d[i] = older_q[i];
    if (load) busy_d[sel_idx] = 1'b0;
    if (accept) begin
      busy_d[alloc_idx]  = 1'b1;
      older_d[alloc_idx] = '0;
      for (int j = 0; j < DEPTH; j++) older_d[j][alloc_idx] = busy_q[j];
    end
    count_d = count_q + 4'(accept) - 4'(load);
  end

  // Entry payload: written on allocation, otherwise updated by CDB wakeup.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (alloc_idx == IW'(i))) begin
        op_q[i] <= issue_op;
        if (cdb_hit(cdb_valid, cdb_tag, issue_tag_1)) begin
          val1_q[i] <= cdb_val;
          tag1_q[i] <= INVALID_TAG;
        end else begin
          val1_q[i] <= issue_val_1;
          tag1_q[i] <= issue_tag_1;
        end
        if (cdb_hit(cdb_valid, cdb_tag, issue_tag_2)) begin
          val2_q[i] <= cdb_val;
          tag2_q[i] <= INVALID_TAG;
        end else begin
          val2_q[i] <= issue_val_2;
          tag2_q[i] <= issue_tag_2;
        end
      end else if (busy_q[i]) begin
        if (cdb_hit(cdb_valid, cdb_tag, tag1_q[i])) begin
          val1_q[i] <= cdb_val;
          tag1_q[i] <= INVALID_TAG;
        end
        if (cdb_hit(cdb_valid, cdb_tag, tag2_q[i])) begin
          val2_q[i] <= cdb_val;
          tag2_q[i] <= INVALID_TAG;
        end
      end
    end
  end

  // Control state and output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
      count_q  <= '0;
      dvalid_q <= 1'b0;
      dop_q    <= '0;
      dval1_q  <= '0;
      dval2_q  <= '0;
      dtag_q   <= '0;
    end else if (flush) begin
      busy_q   <= '0;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
      count_q  <= '0;
      dvalid_q <= 1'b0;
      dop_q    <= '0;
      dval1_q  <= '0;
      dval2_q  <= '0;
      dtag_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= older_d[i];
      count_q <= count_d;
      if (load) begin
        dvalid_q <= 1'b1;
        dop_q    <= op_q[sel_idx];
        dval1_q  <= val1_q[sel_idx];
        dval2_q  <= val2_q[sel_idx];
        dtag_q   <= 5'(TAG_BASE + int'(sel_idx));
      end else if (disp_ready) begin
        dvalid_q <= 1'b0;
      end
    end
  end

  assign issue_ready     = has_free;
  assign issue_alloc_tag = 5'(TAG_BASE + int'(alloc_idx));
  assign disp_valid      = dvalid_q;
  assign disp_op         = dop_q;
  assign disp_val_1      = dval1_q;
  assign disp_val_2      = dval2_q;
  assign disp_tag        = dtag_q;
  assign count           = count_q;
endmodule
